// File: rtl/fpaddsub_pkg.sv
// Shared widths, state encoding and constants for the FP add/sub normaliser.
package fpaddsub_pkg;
  localparam int MW           = 26;
  localparam int EW           = 8;
  localparam int CW           = 6;
  localparam int ALL_ZERO_CNT = 26;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } norm_state_t;
endpackage

// File: rtl/fpaddsub_norm_shifter_if.sv
// Operand/result handshake bundle between the mantissa stage, normaliser and rounder.
interface fpaddsub_norm_shifter_if;
  import fpaddsub_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] mant_in;
  logic [EW-1:0] exp_in;
  logic [CW-1:0] shift_in;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] mant_out;
  logic [EW-1:0] exp_out;
  logic          zero;
  logic          underflow;
  logic          busy;

  modport master (
    output in_valid, mant_in, exp_in, shift_in, out_ready,
    input  in_ready, out_valid, mant_out, exp_out, zero, underflow, busy
  );

  modport slave (
    input  in_valid, mant_in, exp_in, shift_in, out_ready,
    output in_ready, out_valid, mant_out, exp_out, zero, underflow, busy
  );
endinterface

// File: rtl/fpaddsub_step_shifter.sv
// One normalisation step: left shift by min(rem, STEP), zero-fill; combinational.
// Returns the shifted mantissa and the remaining shift count.
module fpaddsub_step_shifter
  import fpaddsub_pkg::*;
#(
  parameter int STEP = 8
) (
  input  logic [MW-1:0] mant_in,
  input  logic [CW-1:0] rem_in,
  output logic [MW-1:0] mant_out,
  output logic [CW-1:0] rem_out
);
  localparam logic [CW-1:0] STEP_C = CW'(STEP);

  logic [CW-1:0] amt;

  always_comb begin
    amt      = (rem_in > STEP_C) ? STEP_C : rem_in;
    mant_out = mant_in << amt;
    rem_out  = rem_in - amt;
  end
endmodule

// File: rtl/fpaddsub_norm_shifter.sv
// Sequential normaliser: 1 + ceil(eff/STEP) cycles from accept to result valid.
// Accepts only in IDLE; result held in HOLD until out_ready, no overlap between ops.
module fpaddsub_norm_shifter
  import fpaddsub_pkg::*;
#(
  parameter int STEP = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  fpaddsub_norm_shifter_if.slave io
);
  norm_state_t   state_q, state_d;
  logic [MW-1:0] mant_q;
  logic [EW-1:0] exp_q;
  logic [CW-1:0] rem_q;
  logic          zero_q;
  logic          uflow_q;

  logic [MW-1:0] step_mant;
  logic [CW-1:0] step_rem;
  logic          all_zero;
  logic          under;
  logic [CW-1:0] eff;
  logic [EW-1:0] exp_adj;

  fpaddsub_step_shifter #(.STEP(STEP)) u_step (
    .mant_in  (mant_q),
    .rem_in   (rem_q),
    .mant_out (step_mant),
    .rem_out  (step_rem)
  );

  // Underflow limits the shift so the exponent lands at 0 (denormal) rather than wrapping.
  always_comb begin
    all_zero = io.shift_in >= CW'(ALL_ZERO_CNT);
    under    = EW'(io.shift_in) >= io.exp_in;
    eff      = io.shift_in;
    exp_adj  = io.exp_in - EW'(io.shift_in);
    if (under) begin
      eff     = (io.exp_in == '0) ? '0 : CW'(io.exp_in - EW'(1));
      exp_adj = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io.in_valid) state_d = (all_zero || eff == '0) ? HOLD : SHIFT;
      SHIFT:   if (step_rem == '0) state_d = HOLD;
      HOLD:    if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mant_q  <= '0;
      exp_q   <= '0;
      rem_q   <= '0;
      zero_q  <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (io.in_valid) begin
            if (all_zero) begin
              mant_q  <= '0;
              exp_q   <= '0;
              rem_q   <= '0;
              zero_q  <= 1'b1;
              uflow_q <= 1'b0;
            end else begin
              mant_q  <= io.mant_in;
              exp_q   <= exp_adj;
              rem_q   <= eff;
              zero_q  <= 1'b0;
              uflow_q <= under;
            end
          end
        end
        SHIFT: begin
          mant_q <= step_mant;
          rem_q  <= step_rem;
        end
        HOLD: begin
          if (io.out_ready) begin
            zero_q  <= 1'b0;
            uflow_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == HOLD);
  assign io.busy      = (state_q != IDLE);
  assign io.mant_out  = mant_q;
  assign io.exp_out   = exp_q;
  assign io.zero      = zero_q;
  assign io.underflow = uflow_q;
endmodule

// File: tb/tb_fpaddsub_norm_shifter.sv
// Directed-vector bench for the normaliser; expected results queued by the driver, checked by a monitor.
module tb_fpaddsub_norm_shifter;
  logic clk = 1'b0;
  logic rst_n;

  fpaddsub_norm_shifter_if ifc ();

  fpaddsub_norm_shifter #(.STEP(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] mant;
    logic [7:0]  exp;
    logic        z;
    logic        u;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   accept_cyc = 0;
  bit   prev_ov  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: compares the presented result against the queue head on every valid cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (ifc.in_valid && ifc.in_ready) accept_cyc = cyc + 1;
      if (ifc.out_valid) begin
        check("in_ready_low_while_valid", {31'd0, ifc.in_ready}, 32'd0);
        if (sb.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          check("mant_out", {6'd0, ifc.mant_out}, {6'd0, sb[0].mant});
          check("exp_out", {24'd0, ifc.exp_out}, {24'd0, sb[0].exp});
          check("zero", {31'd0, ifc.zero}, {31'd0, sb[0].z});
          check("underflow", {31'd0, ifc.underflow}, {31'd0, sb[0].u});
          if (!prev_ov) check("latency", cyc - accept_cyc + 1, sb[0].lat);
          if (ifc.out_ready) void'(sb.pop_front());
        end
      end
      prev_ov = ifc.out_valid;
    end
  end

  task automatic push(input logic [25:0] m, input logic [7:0] e, input logic z, input logic u,
                      input int lat);
    exp_t x;
    x.mant = m; x.exp = e; x.z = z; x.u = u; x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic drive(input logic [25:0] m, input logic [7:0] e, input logic [5:0] s);
    ifc.mant_in  = m;
    ifc.exp_in   = e;
    ifc.shift_in = s;
    ifc.in_valid = 1'b1;
  endtask

  // Holds in_valid until an edge with in_ready; returns edges waited.
  task automatic wait_accept(output int n);
    bit rdy;
    bit ok = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      rdy = ifc.in_ready;
      @(posedge clk); #1;
      n++;
      if (rdy) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("accept_timeout");
    ifc.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      fail_now("drain_timeout");
      sb.delete();
    end
  endtask

  task automatic run(input logic [25:0] m, input logic [7:0] e, input logic [5:0] s,
                     input logic [25:0] em, input logic [7:0] ee, input logic z, input logic u,
                     input int lat);
    int n;
    push(em, ee, z, u, lat);
    drive(m, e, s);
    wait_accept(n);
    drain();
  endtask

  initial begin
    int n;
    bit ok;
    rst_n         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    ifc.mant_in   = '0;
    ifc.exp_in    = '0;
    ifc.shift_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    check("rst_mant", {6'd0, ifc.mant_out}, 32'd0);
    check("rst_exp", {24'd0, ifc.exp_out}, 32'd0);
    check("rst_flags", {30'd0, ifc.zero, ifc.underflow}, 32'd0);
    check("rst_busy", {31'd0, ifc.busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //  mant_in      exp   sh    mant_out     exp  z  u  lat
    run(26'h0400000, 8'd127, 6'd3,  26'h2000000, 8'd124, 0, 0, 2);
    run(26'h0000001, 8'd100, 6'd25, 26'h2000000, 8'd75,  0, 0, 5);
    run(26'h0000000, 8'd50,  6'd26, 26'h0000000, 8'd0,   1, 0, 1);
    run(26'h0000100, 8'd5,   6'd17, 26'h0001000, 8'd0,   0, 1, 2);
    run(26'h2000000, 8'd10,  6'd0,  26'h2000000, 8'd10,  0, 0, 1);
    run(26'h0000000, 8'd3,   6'd40, 26'h0000000, 8'd0,   1, 0, 1);
    run(26'h0010000, 8'd200, 6'd9,  26'h2000000, 8'd191, 0, 0, 3);
    run(26'h0100000, 8'd0,   6'd5,  26'h0100000, 8'd0,   0, 1, 1);
    run(26'h0000200, 8'd17,  6'd16, 26'h2000000, 8'd1,   0, 0, 3);
    run(26'h0000020, 8'd20,  6'd20, 26'h1000000, 8'd0,   0, 1, 4);

    // Backpressure: result held with a second operand waiting upstream.
    ifc.out_ready = 1'b0;
    push(26'h2000000, 8'd124, 0, 0, 2);
    drive(26'h0400000, 8'd127, 6'd3);
    wait_accept(n);
    push(26'h2000000, 8'd8, 0, 0, 4);
    drive(26'h0000008, 8'd30, 6'd22);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ifc.out_valid) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) fail_now("hold_reach");
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_in_ready", {31'd0, ifc.in_ready}, 32'd0);
      check("hold_out_valid", {31'd0, ifc.out_valid}, 32'd1);
    end
    ifc.out_ready = 1'b1;
    wait_accept(n);
    check("accept_after_release", n, 32'd2);
    drain();

    // Reset in the middle of a long shift.
    drive(26'h0000001, 8'd100, 6'd25);
    wait_accept(n);
    @(posedge clk); #1;
    check("busy_mid_shift", {31'd0, ifc.busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_in_ready", {31'd0, ifc.in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    check("abort_flags", {30'd0, ifc.zero, ifc.underflow}, 32'd0);
    check("abort_busy", {31'd0, ifc.busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(26'h0000001, 8'd100, 6'd25, 26'h2000000, 8'd75, 0, 0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/fpaddsub_norm_shifter.md
Name: fpaddsub_norm_shifter

Overview:
- Sequential normaliser that consumes the leading-nought count produced for the FP add/sub datapath.
- Left-shifts the 26-bit post-add mantissa by that count, a bounded number of bits per cycle, and adjusts the 8-bit exponent.
- Flags zero and underflow results.
- Sits between the add/sub mantissa stage and the rounding stage, with valid/ready handshakes on both sides.

Parameters:
- MW, 26, mantissa width (hidden bit + 23 fraction + guard/round bits).
- EW, 8, exponent width.
- CW, 6, shift-count width.
- STEP, 8, maximum left-shift bits per SHIFT cycle (1..MW).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  synchronous active-low reset.
- IN_VALID  in  1  input operand valid.
- IN_READY  out  1  block can accept an operand.
- MANT_IN  in  MW  unnormalised mantissa.
- EXP_IN  in  EW  biased exponent before normalisation.
- SHIFT_IN  in  CW  leading-nought count of MANT_IN (0..26; 26 = all zero).
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  downstream accepts result.
- MANT_OUT  out  MW  normalised (or denormal) mantissa.
- EXP_OUT  out  EW  adjusted exponent.
- ZERO  out  1  result is exactly zero.
- UNDERFLOW  out  1  result is denormal (exponent clamped to 0).
- BUSY  out  1  state != IDLE.

Behaviour:
- Reset (RST_N=0 at a CLK edge): state=IDLE; all outputs 0 except IN_READY=1. Reset mid-operation aborts and discards the operand in flight.
- States: IDLE, SHIFT, HOLD. IN_READY=1 only in IDLE; OUT_VALID=1 only in HOLD.
- IDLE, IN_VALID=1: register operand and compute eff shift and exponent:
  - SHIFT_IN>=26 (27..63 treated as 26): MANT_OUT=0, EXP_OUT=0, ZERO=1, UNDERFLOW=0; -> HOLD.
  - Else if SHIFT_IN>=EXP_IN: eff = EXP_IN==0 ? 0 : EXP_IN-1; EXP_OUT=0; UNDERFLOW=1.
  - Else: eff=SHIFT_IN; EXP_OUT=EXP_IN-SHIFT_IN; UNDERFLOW=0.
  - Next state: eff==0 -> HOLD, else -> SHIFT with rem=eff.
- SHIFT, each cycle: mant <<= min(rem,STEP), zero-fill; rem -= that amount; rem==0 after update -> HOLD.
- HOLD: outputs stable while OUT_READY=0. OUT_READY=1 -> IDLE; ZERO/UNDERFLOW cleared; MANT_OUT/EXP_OUT hold their last values.
- Latency: operand accepted at edge t gives OUT_VALID high after edge t+1+ceil(eff/STEP) (eff=0: after t+1). Throughput 1 op per (latency+1) cycles minimum.
- No back-to-back accept in HOLD: an input arriving in HOLD waits, since IN_READY=0.
- IN_VALID while not IN_READY: ignored; upstream must hold its data.
- Invariant: after a non-underflow, non-zero op, MANT_OUT[MW-1]=1.
- All arithmetic is unsigned. EXP_IN-SHIFT_IN is computed only when SHIFT_IN<EXP_IN, so there is no wrap.

Decomposition:
- Shared package fpaddsub_pkg: MW, EW, CW constants, norm_state_t enum (IDLE, SHIFT, HOLD), and constant ALL_ZERO_CNT=26.
- One natural sub-module, fpaddsub_step_shifter: a combinational left shift by min(rem,STEP) returning the shifted mantissa and the new rem.
- The FSM, registers and handshake stay in the top module.

Test Plan:
- MANT_IN=26'h0400000, EXP_IN=8'd127, SHIFT_IN=3 -> after 2 edges OUT_VALID=1, MANT_OUT=26'h2000000, EXP_OUT=124, ZERO=0, UNDERFLOW=0.
- MANT_IN=26'h0000001, EXP_IN=100, SHIFT_IN=25, STEP=8 -> OUT_VALID after t+5, MANT_OUT=26'h2000000, EXP_OUT=75; IN_READY=0 throughout.
- MANT_IN=0, SHIFT_IN=26, EXP_IN=50 -> OUT_VALID after t+1, MANT_OUT=0, EXP_OUT=0, ZERO=1.
- MANT_IN=26'h0000100, EXP_IN=5, SHIFT_IN=17 -> eff=4, MANT_OUT=26'h0001000, EXP_OUT=0, UNDERFLOW=1, OUT_VALID after t+2.
- Hold OUT_READY=0 for 5 cycles in HOLD with IN_VALID=1 -> outputs stable, IN_READY=0, new operand accepted only on the first IDLE cycle after OUT_READY=1.
- Assert RST_N=0 during SHIFT of a 25-bit shift -> next cycle state IDLE, OUT_VALID=0, IN_READY=1, flags 0; a subsequent op completes correctly.
